// File: rtl/plab5_mcore_mem_req_init_pkg.sv
// Shared message layout for the domain-tagged memory protocol: field widths,
// type encodings and packed control payloads for requests and responses.
package plab5_mcore_mem_req_init_pkg;

    localparam int unsigned c_type_nbits   = 3;
    localparam int unsigned c_opaque_nbits = 8;
    localparam int unsigned c_addr_nbits   = 32;
    localparam int unsigned c_len_nbits    = 4;
    localparam int unsigned c_data_nbits   = 128;

    localparam int unsigned c_req_msg_cnbits  = c_type_nbits + c_opaque_nbits + c_addr_nbits + c_len_nbits;
    localparam int unsigned c_resp_msg_cnbits = c_type_nbits + c_opaque_nbits + c_len_nbits;

    typedef enum logic [c_type_nbits-1:0] {
        MEM_READ  = 3'd0,
        MEM_WRITE = 3'd1
    } mem_type_e;

    // {type[46:44], opaque[43:36], addr[35:4], len[3:0]}
    typedef struct packed {
        logic [c_type_nbits-1:0]   msg_type;
        logic [c_opaque_nbits-1:0] opaque;
        logic [c_addr_nbits-1:0]   addr;
        logic [c_len_nbits-1:0]    len;
    } mem_req_ctl_t;

    // {type[14:12], opaque[11:4], len[3:0]}
    typedef struct packed {
        logic [c_type_nbits-1:0]   msg_type;
        logic [c_opaque_nbits-1:0] opaque;
        logic [c_len_nbits-1:0]    len;
    } mem_resp_ctl_t;

endpackage

// File: rtl/plab5_mcore_mem_req_init_if.sv
// Cache-side and network-side request/response channels of the initiator.
interface plab5_mcore_mem_req_init_if;
    import plab5_mcore_mem_req_init_pkg::*;

    logic [c_req_msg_cnbits-1:0]  cache_req_control;
    logic [c_data_nbits-1:0]      cache_req_data;
    logic                         cache_req_val;
    logic                         cache_req_rdy;

    logic [c_req_msg_cnbits-1:0]  net_req_control;
    logic [c_data_nbits-1:0]      net_req_data;
    logic                         net_req_domain;
    logic                         net_req_val;
    logic                         net_req_rdy;

    logic [c_resp_msg_cnbits-1:0] net_resp_control;
    logic [c_data_nbits-1:0]      net_resp_data;
    logic                         net_resp_domain;
    logic                         net_resp_val;
    logic                         net_resp_rdy;

    logic [c_resp_msg_cnbits-1:0] cache_resp_control;
    logic [c_data_nbits-1:0]      cache_resp_data;
    logic                         cache_resp_val;
    logic                         cache_resp_rdy;

    modport slave (
        input  cache_req_control, cache_req_data, cache_req_val,
        output cache_req_rdy,
        output net_req_control, net_req_data, net_req_domain, net_req_val,
        input  net_req_rdy,
        input  net_resp_control, net_resp_data, net_resp_domain, net_resp_val,
        output net_resp_rdy,
        output cache_resp_control, cache_resp_data, cache_resp_val,
        input  cache_resp_rdy
    );

    modport master (
        output cache_req_control, cache_req_data, cache_req_val,
        input  cache_req_rdy,
        input  net_req_control, net_req_data, net_req_domain, net_req_val,
        output net_req_rdy,
        output net_resp_control, net_resp_data, net_resp_domain, net_resp_val,
        input  net_resp_rdy,
        input  cache_resp_control, cache_resp_data, cache_resp_val,
        output cache_resp_rdy
    );

endinterface

// File: rtl/plab5_mcore_tag_scoreboard.sv
// Outstanding-request table: valid bits, lowest-free-index allocation and
// per-tag storage of the original opaque and the issuing domain.
module plab5_mcore_tag_scoreboard
    import plab5_mcore_mem_req_init_pkg::*;
#(
    parameter int unsigned p_num_entries = 4
) (
    input  logic                              clk,
    input  logic                              reset,

    input  logic                              alloc_en,
    input  logic [c_opaque_nbits-1:0]         alloc_opaque,
    input  logic                              alloc_domain,
    output logic                              free_exists_c,
    output logic [$clog2(p_num_entries)-1:0]  alloc_idx_c,

    input  logic [$clog2(p_num_entries)-1:0]  rd_idx,
    input  logic                              free_en,
    output logic                              rd_valid_c,
    output logic [c_opaque_nbits-1:0]         rd_opaque_c,
    output logic                              rd_domain_c,

    output logic [$clog2(p_num_entries):0]    count
);

    localparam int unsigned c_idx_nbits = $clog2(p_num_entries);
    localparam int unsigned c_cnt_nbits = c_idx_nbits + 1;

    logic [p_num_entries-1:0]  valid;
    logic [c_opaque_nbits-1:0] opaque_mem [p_num_entries];
    logic                      domain_mem [p_num_entries];
    logic                      free_hit_c;

    // Lowest-index free entry, looked up from registered valid bits only
    always_comb begin
        free_exists_c = 1'b0;
        alloc_idx_c   = '0;
        for (int i = int'(p_num_entries) - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_exists_c = 1'b1;
                alloc_idx_c   = c_idx_nbits'(i);
            end
        end
    end

    assign rd_valid_c  = valid[rd_idx];
    assign rd_opaque_c = opaque_mem[rd_idx];
    assign rd_domain_c = domain_mem[rd_idx];
    assign free_hit_c  = free_en & valid[rd_idx];

    // A freed tag only becomes allocatable on the following cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            count <= '0;
        end else begin
            if (free_en) valid[rd_idx] <= 1'b0;
            if (alloc_en) valid[alloc_idx_c] <= 1'b1;
            count <= count + c_cnt_nbits'(alloc_en) - c_cnt_nbits'(free_hit_c);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_en) begin
            opaque_mem[alloc_idx_c] <= alloc_opaque;
            domain_mem[alloc_idx_c] <= alloc_domain;
        end
    end

endmodule

// File: rtl/plab5_mcore_mem_req_init.sv
// Requester-side endpoint: tags outgoing requests with the core domain and a
// scoreboard index, and restores/validates the matching responses.
module plab5_mcore_mem_req_init
    import plab5_mcore_mem_req_init_pkg::*;
#(
    parameter int unsigned p_num_entries = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            sec_level,
    plab5_mcore_mem_req_init_if.slave       bus,
    output logic                            dom_err,
    output logic [$clog2(p_num_entries):0]  outstanding
);

    localparam int unsigned c_idx_nbits = $clog2(p_num_entries);

    mem_req_ctl_t              cache_req_ctl;
    mem_req_ctl_t              net_req_ctl;
    mem_resp_ctl_t             net_resp_ctl;
    mem_resp_ctl_t             cache_resp_ctl;
    logic [c_data_nbits-1:0]   net_req_data;
    logic [c_data_nbits-1:0]   cache_resp_data;
    logic                      net_req_val;
    logic                      net_req_domain;
    logic                      cache_resp_val;

    logic                      free_exists_c;
    logic [c_idx_nbits-1:0]    alloc_idx_c;
    logic [c_idx_nbits-1:0]    resp_idx_c;
    logic                      entry_valid_c;
    logic [c_opaque_nbits-1:0] entry_opaque_c;
    logic                      entry_domain_c;
    logic                      req_fire_c;
    logic                      resp_fire_c;
    logic                      resp_ok_c;

    assign cache_req_ctl = bus.cache_req_control;
    assign net_resp_ctl  = bus.net_resp_control;

    assign bus.cache_req_rdy = free_exists_c & (!net_req_val | bus.net_req_rdy);
    assign bus.net_resp_rdy  = !cache_resp_val | bus.cache_resp_rdy;
    assign req_fire_c        = bus.cache_req_val & bus.cache_req_rdy;
    assign resp_fire_c       = bus.net_resp_val & bus.net_resp_rdy;

    assign resp_idx_c = net_resp_ctl.opaque[c_idx_nbits-1:0];
    // Tags above the table size can never have been issued by us
    assign resp_ok_c  = entry_valid_c
                      & (bus.net_resp_domain == entry_domain_c)
                      & ((net_resp_ctl.opaque >> c_idx_nbits) == '0);

    plab5_mcore_tag_scoreboard #(
        .p_num_entries (p_num_entries)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .alloc_en      (req_fire_c),
        .alloc_opaque  (cache_req_ctl.opaque),
        .alloc_domain  (sec_level),
        .free_exists_c (free_exists_c),
        .alloc_idx_c   (alloc_idx_c),
        .rd_idx        (resp_idx_c),
        .free_en       (resp_fire_c),
        .rd_valid_c    (entry_valid_c),
        .rd_opaque_c   (entry_opaque_c),
        .rd_domain_c   (entry_domain_c),
        .count         (outstanding)
    );

    // Request pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            net_req_val <= 1'b0;
        end else if (req_fire_c) begin
            net_req_val <= 1'b1;
        end else if (bus.net_req_rdy) begin
            net_req_val <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire_c) begin
            net_req_ctl        <= cache_req_ctl;
            net_req_ctl.opaque <= c_opaque_nbits'(alloc_idx_c);
            net_req_data       <= bus.cache_req_data;
            net_req_domain     <= sec_level;
        end
    end

    // Response output register; dom_err marks the first cycle of a scrubbed response
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_resp_val <= 1'b0;
            dom_err        <= 1'b0;
        end else begin
            dom_err <= resp_fire_c & !resp_ok_c;
            if (resp_fire_c) begin
                cache_resp_val <= 1'b1;
            end else if (bus.cache_resp_rdy) begin
                cache_resp_val <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resp_fire_c) begin
            cache_resp_ctl.msg_type <= net_resp_ctl.msg_type;
            cache_resp_ctl.len      <= net_resp_ctl.len;
            cache_resp_ctl.opaque   <= entry_valid_c ? entry_opaque_c : net_resp_ctl.opaque;
            cache_resp_data         <= resp_ok_c ? bus.net_resp_data : '0;
        end
    end

    assign bus.net_req_control    = net_req_ctl;
    assign bus.net_req_data       = net_req_data;
    assign bus.net_req_domain     = net_req_domain;
    assign bus.net_req_val        = net_req_val;
    assign bus.cache_resp_control = cache_resp_ctl;
    assign bus.cache_resp_data    = cache_resp_data;
    assign bus.cache_resp_val     = cache_resp_val;

endmodule

// File: tb/tb_plab5_mcore_mem_req_init.sv
// Scoreboard bench: stimulus pushes expected network requests and cache
// responses; a negedge monitor pops and compares on every handshake.
module tb_plab5_mcore_mem_req_init;
    import plab5_mcore_mem_req_init_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       sec_level;
    logic       dom_err;
    logic [2:0] outstanding;

    plab5_mcore_mem_req_init_if bus ();

    plab5_mcore_mem_req_init #(.p_num_entries(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .sec_level   (sec_level),
        .bus         (bus),
        .dom_err     (dom_err),
        .outstanding (outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        mem_req_ctl_t ctl;
        logic [127:0] data;
        logic         dom;
    } exp_req_t;

    typedef struct {
        mem_resp_ctl_t ctl;
        logic [127:0]  data;
        logic          err;
    } exp_resp_t;

    exp_req_t  req_q[$];
    exp_resp_t resp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endfunction

    function automatic void fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endfunction

    task automatic send_req(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                            input logic [127:0] d, input logic [7:0] exp_tag);
        mem_req_ctl_t c;
        exp_req_t     e;
        int           n = 0;
        c.msg_type = t; c.opaque = op; c.addr = a; c.len = 4'd0;
        bus.cache_req_control = c;
        bus.cache_req_data    = d;
        bus.cache_req_val     = 1'b1;
        e.ctl = c; e.ctl.opaque = exp_tag; e.data = d; e.dom = sec_level;
        req_q.push_back(e);
        @(negedge clk);
        while (!bus.cache_req_rdy && n < 50) begin n++; @(negedge clk); end
        if (n >= 50) fail_now("req_accept_timeout");
        @(posedge clk); #1;
        bus.cache_req_val = 1'b0;
    endtask

    task automatic send_resp(input logic [2:0] t, input logic [7:0] op, input logic dom,
                             input logic [127:0] d, input logic [7:0] exp_op,
                             input logic [127:0] exp_d, input logic exp_err);
        mem_resp_ctl_t c;
        exp_resp_t     e;
        int            n = 0;
        c.msg_type = t; c.opaque = op; c.len = 4'd0;
        bus.net_resp_control = c;
        bus.net_resp_data    = d;
        bus.net_resp_domain  = dom;
        bus.net_resp_val     = 1'b1;
        e.ctl = c; e.ctl.opaque = exp_op; e.data = exp_d; e.err = exp_err;
        resp_q.push_back(e);
        @(negedge clk);
        while (!bus.net_resp_rdy && n < 50) begin n++; @(negedge clk); end
        if (n >= 50) fail_now("resp_accept_timeout");
        @(posedge clk); #1;
        bus.net_resp_val = 1'b0;
    endtask

    // Monitor: compares every handshake and the dom_err pulse position
    initial begin
        logic      pending;
        logic      is_new;
        exp_req_t  er;
        exp_resp_t es;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pending = 1'b0;
            end else begin
                is_new = bus.cache_resp_val && !pending;
                if (is_new && resp_q.size() == 0) fail_now("cache_resp_unexpected");
                else chk("dom_err", 128'(dom_err), 128'(is_new ? resp_q[0].err : 1'b0));
                if (bus.cache_resp_val && bus.cache_resp_rdy && resp_q.size() != 0) begin
                    es = resp_q.pop_front();
                    chk("cache_resp_control", 128'(bus.cache_resp_control), 128'(es.ctl));
                    chk("cache_resp_data", bus.cache_resp_data, es.data);
                end
                pending = bus.cache_resp_val && !bus.cache_resp_rdy;
                if (bus.net_req_val && bus.net_req_rdy) begin
                    if (req_q.size() == 0) fail_now("net_req_unexpected");
                    else begin
                        er = req_q.pop_front();
                        chk("net_req_control", 128'(bus.net_req_control), 128'(er.ctl));
                        chk("net_req_data", bus.net_req_data, er.data);
                        chk("net_req_domain", 128'(bus.net_req_domain), 128'(er.dom));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; sec_level = 1'b0;
        bus.cache_req_control = '0; bus.cache_req_data = '0; bus.cache_req_val = 1'b0;
        bus.net_resp_control = '0; bus.net_resp_data = '0; bus.net_resp_domain = 1'b0;
        bus.net_resp_val = 1'b0; bus.net_req_rdy = 1'b1; bus.cache_resp_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_net_req_val", 128'(bus.net_req_val), 128'(0));
        chk("rst_cache_resp_val", 128'(bus.cache_resp_val), 128'(0));
        chk("rst_dom_err", 128'(dom_err), 128'(0));
        chk("rst_outstanding", 128'(outstanding), 128'(0));
        chk("rst_cache_req_rdy", 128'(bus.cache_req_rdy), 128'(1));
        @(posedge clk); #1;

        // Basic read round trip
        send_req(MEM_READ, 8'h5A, 32'h1000, 128'h0, 8'h00);
        chk("t1_outstanding", 128'(outstanding), 128'(1));
        send_resp(MEM_READ, 8'h00, 1'b0, 128'hDEAD, 8'h5A, 128'hDEAD, 1'b0);
        chk("t1_outstanding_after", 128'(outstanding), 128'(0));

        // Domain mismatch; sec_level change after issue must not matter
        sec_level = 1'b1;
        send_req(MEM_WRITE, 8'h77, 32'h2000, 128'h1234, 8'h00);
        sec_level = 1'b0;
        send_resp(MEM_WRITE, 8'h00, 1'b0, 128'hBEEF, 8'h77, 128'h0, 1'b1);
        chk("t2_outstanding", 128'(outstanding), 128'(0));

        // Fill the table: tags 0..3 in order
        for (int i = 0; i < 4; i++)
            send_req(MEM_READ, 8'(8'h10 + i), 32'(i) << 8, 128'(i + 1), 8'(i));
        chk("full_outstanding", 128'(outstanding), 128'(4));

        // Full: request stalls until tag 2 frees, then reuses tag 2
        fork
            send_req(MEM_READ, 8'h20, 32'h3000, 128'h20, 8'h02);
            begin
                @(negedge clk);
                chk("full_cache_req_rdy", 128'(bus.cache_req_rdy), 128'(0));
                @(posedge clk); #1;
                send_resp(MEM_READ, 8'h02, 1'b0, 128'h22, 8'h12, 128'h22, 1'b0);
            end
        join
        chk("reuse_outstanding", 128'(outstanding), 128'(4));
        send_resp(MEM_READ, 8'h00, 1'b0, 128'hA0, 8'h10, 128'hA0, 1'b0);
        send_resp(MEM_READ, 8'h01, 1'b0, 128'hA1, 8'h11, 128'hA1, 1'b0);
        send_resp(MEM_READ, 8'h03, 1'b0, 128'hA3, 8'h13, 128'hA3, 1'b0);
        send_resp(MEM_READ, 8'h02, 1'b0, 128'hA2, 8'h20, 128'hA2, 1'b0);
        chk("drain_outstanding", 128'(outstanding), 128'(0));

        // Same-cycle alloc and free: count unchanged, freed tag not reused
        send_req(MEM_READ, 8'h60, 32'h4000, 128'h0, 8'h00);
        fork
            send_req(MEM_READ, 8'h61, 32'h4100, 128'h0, 8'h01);
            send_resp(MEM_READ, 8'h00, 1'b0, 128'hC0, 8'h60, 128'hC0, 1'b0);
        join
        chk("simul_outstanding", 128'(outstanding), 128'(1));
        send_resp(MEM_READ, 8'h01, 1'b0, 128'hC1, 8'h61, 128'hC1, 1'b0);

        // Bogus tags: upper bits set, invalid entry, valid entry with upper bits
        send_resp(MEM_READ, 8'h13, 1'b0, 128'hAA, 8'h13, 128'h0, 1'b1);
        send_resp(MEM_READ, 8'h01, 1'b1, 128'hBB, 8'h01, 128'h0, 1'b1);
        send_req(MEM_READ, 8'h44, 32'h5000, 128'h0, 8'h00);
        send_resp(MEM_READ, 8'h04, 1'b0, 128'hCC, 8'h44, 128'h0, 1'b1);
        chk("bogus_outstanding", 128'(outstanding), 128'(0));

        // Response backpressure: second response waits, order preserved
        sec_level = 1'b1;
        send_req(MEM_READ, 8'h31, 32'h6000, 128'h0, 8'h00);
        send_req(MEM_READ, 8'h32, 32'h6100, 128'h0, 8'h01);
        bus.cache_resp_rdy = 1'b0;
        send_resp(MEM_READ, 8'h00, 1'b1, 128'hF1, 8'h31, 128'hF1, 1'b0);
        @(negedge clk);
        chk("bp_net_resp_rdy", 128'(bus.net_resp_rdy), 128'(0));
        @(posedge clk); #1;
        fork
            send_resp(MEM_READ, 8'h01, 1'b1, 128'hF2, 8'h32, 128'hF2, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1 bus.cache_resp_rdy = 1'b1;
            end
        join
        chk("bp_outstanding", 128'(outstanding), 128'(0));

        // Reset with a stalled request and a stalled response in flight
        sec_level = 1'b0;
        bus.net_req_rdy = 1'b0;
        send_req(MEM_READ, 8'h55, 32'h7000, 128'h0, 8'h00);
        bus.cache_resp_rdy = 1'b0;
        send_resp(MEM_READ, 8'h07, 1'b0, 128'h77, 8'h07, 128'h0, 1'b1);
        chk("pre_rst_outstanding", 128'(outstanding), 128'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        req_q.delete();
        resp_q.delete();
        chk("mid_rst_net_req_val", 128'(bus.net_req_val), 128'(0));
        chk("mid_rst_cache_resp_val", 128'(bus.cache_resp_val), 128'(0));
        chk("mid_rst_outstanding", 128'(outstanding), 128'(0));
        chk("mid_rst_dom_err", 128'(dom_err), 128'(0));
        bus.net_req_rdy = 1'b1;
        bus.cache_resp_rdy = 1'b1;
        send_resp(MEM_READ, 8'h00, 1'b0, 128'h99, 8'h00, 128'h0, 1'b1);
        chk("post_rst_outstanding", 128'(outstanding), 128'(0));

        n = 0;
        while ((req_q.size() != 0 || resp_q.size() != 0) && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (req_q.size() != 0 || resp_q.size() != 0) fail_now("drain_timeout");
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
